// File: rtl/bus_arbiter_pkg.sv
// Shared types and widths for the round-robin Wishbone bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_t;

    localparam int WDOG_W        = 10;
    localparam int BUS_ADDRWIDTH = 30;
    localparam int BUS_DATAWIDTH = 32;
    localparam int BUS_SELWIDTH  = 4;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side and shared slave-side Wishbone signals seen by the arbiter.
interface bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NMASTERS = 2
);
    logic [NMASTERS-1:0]               m_cyc;
    logic [NMASTERS-1:0]               m_stb;
    logic [NMASTERS-1:0]               m_we;
    logic [NMASTERS*BUS_ADDRWIDTH-1:0] m_addr;
    logic [NMASTERS*BUS_DATAWIDTH-1:0] m_data_m2s;
    logic [NMASTERS*BUS_SELWIDTH-1:0]  m_sel;
    logic [BUS_DATAWIDTH-1:0]          m_data_s2m;
    logic [NMASTERS-1:0]               m_ack;
    logic [NMASTERS-1:0]               m_err;
    logic [NMASTERS-1:0]               m_stall;

    logic                              s_cyc;
    logic                              s_stb;
    logic                              s_we;
    logic [BUS_ADDRWIDTH-1:0]          s_addr;
    logic [BUS_DATAWIDTH-1:0]          s_data_m2s;
    logic [BUS_SELWIDTH-1:0]           s_sel;
    logic [BUS_DATAWIDTH-1:0]          s_data_s2m;
    logic                              s_ack;
    logic                              s_err;
    logic                              s_stall;

    logic [NMASTERS-1:0]               grant;

    modport arb (
        input  m_cyc, m_stb, m_we, m_addr, m_data_m2s, m_sel,
        output m_data_s2m, m_ack, m_err, m_stall,
        output s_cyc, s_stb, s_we, s_addr, s_data_m2s, s_sel,
        input  s_data_s2m, s_ack, s_err, s_stall,
        output grant
    );

    modport master (
        output m_cyc, m_stb, m_we, m_addr, m_data_m2s, m_sel,
        input  m_data_s2m, m_ack, m_err, m_stall, grant
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_addr, s_data_m2s, s_sel,
        output s_data_s2m, s_ack, s_err, s_stall
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after the last owner,
// so the last owner itself is checked last.
module bus_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   last,
    output logic [N-1:0] pick,
    output logic         valid
);

    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == ((int'(last) + k) % N))) begin
                    pick[i] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter muxing NMASTERS Wishbone masters onto one pipelined
// slave port, with outstanding-transfer tracking and a hung-cycle watchdog.
//   state     | meaning
//   ARB_IDLE  | no owner, all masters stalled
//   ARB_GRANT | owner drives the shared bus
//   ARB_ABORT | bus dropped after timeout, waiting for owner to drop cyc
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NMASTERS        = 2,
    parameter int TIMEOUT         = 255,
    parameter int MAX_OUTSTANDING = 7
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.arb    bus
);

    localparam logic [2:0]        MAX_OUT = 3'(MAX_OUTSTANDING);
    localparam logic [WDOG_W-1:0] TMO     = WDOG_W'(TIMEOUT);

    arb_state_t          state_q, state_d;
    logic [NMASTERS-1:0] grant_q, grant_d;
    logic [1:0]          last_q, last_d;
    logic [2:0]          out_q, out_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;

    logic [NMASTERS-1:0] pick;
    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic                own_cyc, own_stb, full, stb_ok, timeout, inc, dec;

    bus_rr_pick #(.N(NMASTERS)) u_pick (
        .req   (bus.m_cyc),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (pick[i]) pick_idx = 2'(i);
        end
    end

    assign own_cyc = |(bus.m_cyc & grant_q);
    assign own_stb = |(bus.m_stb & grant_q);
    assign full    = (out_q == MAX_OUT);
    assign stb_ok  = (state_q == ARB_GRANT) && own_stb && !full;
    assign timeout = (state_q == ARB_GRANT) && own_cyc && (wdog_q >= TMO);
    assign inc     = stb_ok && !bus.s_stall;
    assign dec     = bus.s_ack || bus.s_err;

    // Shared-bus mux and per-master responses; combinational through grant_q.
    always_comb begin
        bus.s_cyc      = 1'b0;
        bus.s_stb      = 1'b0;
        bus.s_we       = 1'b0;
        bus.s_addr     = '0;
        bus.s_data_m2s = '0;
        bus.s_sel      = '0;
        bus.m_ack      = '0;
        bus.m_err      = '0;
        bus.m_stall    = '1;
        if (state_q == ARB_GRANT) begin
            bus.s_cyc = own_cyc;
            bus.s_stb = stb_ok;
            bus.s_we  = |(bus.m_we & grant_q);
            for (int i = 0; i < NMASTERS; i++) begin
                if (grant_q[i]) begin
                    bus.s_addr     = bus.m_addr[i*BUS_ADDRWIDTH +: BUS_ADDRWIDTH];
                    bus.s_data_m2s = bus.m_data_m2s[i*BUS_DATAWIDTH +: BUS_DATAWIDTH];
                    bus.s_sel      = bus.m_sel[i*BUS_SELWIDTH +: BUS_SELWIDTH];
                end
            end
            bus.m_ack   = grant_q & {NMASTERS{bus.s_ack}};
            bus.m_err   = grant_q & {NMASTERS{bus.s_err | timeout}};
            bus.m_stall = ~grant_q | (grant_q & {NMASTERS{bus.s_stall | full}});
        end
        bus.m_data_s2m = bus.s_data_s2m;
        bus.grant      = grant_q;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        out_d   = out_q;
        wdog_d  = wdog_q;
        case (state_q)
            ARB_IDLE: begin
                out_d  = '0;
                wdog_d = '0;
                if (pick_valid) begin
                    grant_d = pick;
                    last_d  = pick_idx;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (!own_cyc) begin
                    // Release: hand over in the same cycle, old owner ranked last.
                    out_d  = '0;
                    wdog_d = '0;
                    if (pick_valid) begin
                        grant_d = pick;
                        last_d  = pick_idx;
                    end else begin
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end
                end else if (timeout) begin
                    wdog_d  = '0;
                    state_d = ARB_ABORT;
                end else begin
                    if (inc && !dec)                     out_d = out_q + 3'd1;
                    else if (dec && !inc && out_q != '0) out_d = out_q - 3'd1;
                    if (dec || (out_q == '0 && !(stb_ok && bus.s_stall)))
                        wdog_d = '0;
                    else
                        wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ARB_ABORT: begin
                wdog_d = '0;
                if (!own_cyc) begin
                    out_d   = '0;
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= 2'(NMASTERS - 1);
            out_q   <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            out_q   <= out_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: 2 masters, TIMEOUT=8, MAX_OUTSTANDING=2.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NMASTERS(2)) bif ();

    bus_arbiter #(
        .NMASTERS        (2),
        .TIMEOUT         (8),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.arb)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst            = 1'b1;
        bif.m_cyc      = '0;
        bif.m_stb      = '0;
        bif.m_we       = '0;
        bif.m_addr     = '0;
        bif.m_data_m2s = '0;
        bif.m_sel      = '0;
        bif.s_data_s2m = '0;
        bif.s_ack      = 1'b0;
        bif.s_err      = 1'b0;
        bif.s_stall    = 1'b0;
        step();
        step();
        chk("rst_grant", bif.grant, 2'b00);
        chk("rst_stall", bif.m_stall, 2'b11);
        chk("rst_scyc", bif.s_cyc, 1'b0);
        chk("rst_sstb", bif.s_stb, 1'b0);
        chk("rst_saddr", bif.s_addr, 30'h0);
        chk("rst_mack", bif.m_ack, 2'b00);
        rst = 1'b0;

        // single master 1, three pipelined reads
        bif.m_cyc          = 2'b10;
        bif.m_stb          = 2'b10;
        bif.m_addr[30 +: 30] = 30'h0000_1001;
        #1;
        chk("t1_pre_grant", bif.grant, 2'b00);
        chk("t1_pre_scyc", bif.s_cyc, 1'b0);
        step();
        chk("t1_grant", bif.grant, 2'b10);
        chk("t1_scyc", bif.s_cyc, 1'b1);
        chk("t1_stb1", bif.s_stb, 1'b1);
        chk("t1_addr1", bif.s_addr, 30'h0000_1001);
        chk("t1_stall1", bif.m_stall, 2'b01);
        step();
        bif.m_addr[30 +: 30] = 30'h0000_1002;
        bif.s_ack      = 1'b1;
        bif.s_data_s2m = 32'hCAFE_0001;
        #1;
        chk("t1_stb2", bif.s_stb, 1'b1);
        chk("t1_addr2", bif.s_addr, 30'h0000_1002);
        chk("t1_ack1", bif.m_ack, 2'b10);
        chk("t1_rdata", bif.m_data_s2m, 32'hCAFE_0001);
        step();
        bif.m_addr[30 +: 30] = 30'h0000_1003;
        #1;
        chk("t1_stb3", bif.s_stb, 1'b1);
        chk("t1_ack2", bif.m_ack, 2'b10);
        chk("t1_stall3", bif.m_stall, 2'b01);
        step();
        bif.m_stb = 2'b00;
        #1;
        chk("t1_nostb", bif.s_stb, 1'b0);
        chk("t1_ack3", bif.m_ack, 2'b10);
        step();
        bif.s_ack = 1'b0;
        bif.m_cyc = 2'b00;
        #1;
        chk("t1_rel_scyc", bif.s_cyc, 1'b0);
        step();
        chk("t1_idle_grant", bif.grant, 2'b00);

        // simultaneous requests out of reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        bif.m_addr[0 +: 30]      = 30'h0000_0A00;
        bif.m_addr[30 +: 30]     = 30'h0000_0B00;
        bif.m_data_m2s[0 +: 32]  = 32'h1111_2222;
        bif.m_data_m2s[32 +: 32] = 32'h3333_4444;
        bif.m_sel                = 8'h3C;
        bif.m_we                 = 2'b01;
        bif.m_cyc                = 2'b11;
        step();
        chk("t2_grant_m0", bif.grant, 2'b01);
        chk("t2_addr_m0", bif.s_addr, 30'h0000_0A00);
        chk("t2_wdata_m0", bif.s_data_m2s, 32'h1111_2222);
        chk("t2_sel_m0", bif.s_sel, 4'hC);
        chk("t2_we_m0", bif.s_we, 1'b1);
        bif.m_cyc = 2'b10;
        #1;
        chk("t2_rel_scyc", bif.s_cyc, 1'b0);
        step();
        chk("t2_grant_m1", bif.grant, 2'b10);
        chk("t2_scyc_m1", bif.s_cyc, 1'b1);
        chk("t2_addr_m1", bif.s_addr, 30'h0000_0B00);
        chk("t2_sel_m1", bif.s_sel, 4'h3);
        chk("t2_we_m1", bif.s_we, 1'b0);
        bif.m_cyc = 2'b11;
        step();
        chk("t2_hold_m1", bif.grant, 2'b10);
        bif.m_cyc = 2'b01;
        step();
        chk("t2_back_m0", bif.grant, 2'b01);
        bif.m_cyc = 2'b00;
        bif.m_we  = 2'b00;
        step();
        chk("t2_idle", bif.grant, 2'b00);

        // backpressure with MAX_OUTSTANDING=2
        bif.m_cyc = 2'b01;
        bif.m_addr[0 +: 30] = 30'h0000_0C00;
        step();
        chk("t3_grant", bif.grant, 2'b01);
        bif.m_stb = 2'b01;
        #1;
        chk("t3_stb1", bif.s_stb, 1'b1);
        step();
        chk("t3_stb2", bif.s_stb, 1'b1);
        step();
        chk("t3_full_stb", bif.s_stb, 1'b0);
        chk("t3_full_stall", bif.m_stall, 2'b11);
        step();
        chk("t3_still_full", bif.s_stb, 1'b0);
        bif.s_ack = 1'b1;
        #1;
        chk("t3_ack", bif.m_ack, 2'b01);
        step();
        bif.s_ack = 1'b0;
        #1;
        chk("t3_stb3", bif.s_stb, 1'b1);
        chk("t3_stall3", bif.m_stall, 2'b10);
        step();
        bif.m_stb = 2'b00;
        bif.s_ack = 1'b1;
        step();
        step();
        bif.s_ack = 1'b0;
        bif.m_cyc = 2'b00;
        step();
        chk("t3_idle", bif.grant, 2'b00);

        // simultaneous inc/dec, then watchdog timeout
        bif.m_cyc = 2'b01;
        step();
        bif.m_stb = 2'b01;
        step();
        bif.m_stb = 2'b00;
        step();
        step();
        step();
        bif.m_stb = 2'b01;
        bif.s_ack = 1'b1;
        step();
        bif.s_ack = 1'b0;
        #1;
        chk("t4_incdec_stb", bif.s_stb, 1'b1);
        step();
        chk("t4_full_after", bif.s_stb, 1'b0);
        bif.m_stb = 2'b00;
        #1;
        chk("t4_noerr_1", bif.m_err, 2'b00);
        for (int k = 2; k <= 7; k++) begin
            step();
            chk($sformatf("t4_noerr_%0d", k), bif.m_err, 2'b00);
        end
        step();
        chk("t4_timeout_err", bif.m_err, 2'b01);
        chk("t4_timeout_scyc", bif.s_cyc, 1'b1);
        step();
        bif.s_ack = 1'b1;
        #1;
        chk("t4_abort_err", bif.m_err, 2'b00);
        chk("t4_late_ack", bif.m_ack, 2'b00);
        chk("t4_abort_scyc", bif.s_cyc, 1'b0);
        chk("t4_abort_stall", bif.m_stall, 2'b11);
        chk("t4_abort_grant", bif.grant, 2'b01);
        bif.s_ack = 1'b0;
        bif.m_cyc = 2'b00;
        step();
        chk("t4_idle", bif.grant, 2'b00);

        // reset mid-burst with two outstanding
        bif.m_cyc = 2'b01;
        step();
        bif.m_stb = 2'b01;
        step();
        step();
        chk("t5_full", bif.m_stall, 2'b11);
        chk("t5_full_stb", bif.s_stb, 1'b0);
        rst = 1'b1;
        step();
        bif.s_ack = 1'b1;
        #1;
        chk("t5_rst_grant", bif.grant, 2'b00);
        chk("t5_rst_scyc", bif.s_cyc, 1'b0);
        chk("t5_rst_stall", bif.m_stall, 2'b11);
        chk("t5_rst_ack", bif.m_ack, 2'b00);
        rst       = 1'b0;
        bif.s_ack = 1'b0;
        step();
        chk("t5_regrant", bif.grant, 2'b01);
        chk("t5_regrant_stb", bif.s_stb, 1'b1);
        bif.m_stb = 2'b00;
        bif.m_cyc = 2'b00;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
